// File: rtl/matmul_tile_sequencer_pkg.sv
// Shared types and elaboration helpers for the matmul tile sequencer.
// State encoding, width helpers and derived-dimension functions.
package matmul_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_CORE = 3'd1,
        S_ISSUE     = 3'd2,
        S_DRAIN     = 3'd3,
        S_WAIT_RES  = 3'd4,
        S_WRITE     = 3'd5,
        S_DONE      = 3'd6
    } seq_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    // Counter width that stays legal for a count of one.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

    function automatic int div_dim(input int dim, input int by);
        return dim / by;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/matmul_tile_sequencer_if.sv
// Handshake and BRAM/core bus of the tile sequencer.
// master = sequencer side, slave = BRAMs, systolic core and controller.
interface matmul_tile_sequencer_if #(
    parameter int DW     = 64,
    parameter int ADDR_W = 14
);
    logic              start;
    logic              ready;
    logic              done;
    logic              in_enb;
    logic [ADDR_W-1:0] in_addrb;
    logic [DW-1:0]     in_doutb;
    logic              wb_enb;
    logic [ADDR_W-1:0] wb_addrb;
    logic [DW-1:0]     wb_doutb;
    logic              core_ready;
    logic              core_acc_clr;
    logic              core_in_valid;
    logic [DW-1:0]     core_in_data;
    logic [DW-1:0]     core_wb_data;
    logic              core_out_valid;
    logic [DW-1:0]     core_out_data;
    logic              out_wea;
    logic [ADDR_W-1:0] out_addra;
    logic [DW-1:0]     out_dina;
    logic              err;
    logic [31:0]       cycle_cnt;

    modport master (
        input  start, in_doutb, wb_doutb, core_ready, core_out_valid, core_out_data,
        output ready, done, in_enb, in_addrb, wb_enb, wb_addrb, core_acc_clr,
               core_in_valid, core_in_data, core_wb_data, out_wea, out_addra,
               out_dina, err, cycle_cnt
    );

    modport slave (
        output start, in_doutb, wb_doutb, core_ready, core_out_valid, core_out_data,
        input  ready, done, in_enb, in_addrb, wb_enb, wb_addrb, core_acc_clr,
               core_in_valid, core_in_data, core_wb_data, out_wea, out_addra,
               out_dina, err, cycle_cnt
    );
endinterface

// File: rtl/matmul_tile_sequencer_tile_loop_counter.sv
// Nested row/col/chunk loop indices for the tile walk (k innermost, then c, then r).
// Latency: indices update the cycle after inc_k/inc_tile; flags are combinational.
// Backpressure: none, advances only when the FSM pulses an increment.
module tile_loop_counter
    import matmul_seq_pkg::*;
#(
    parameter int K_CHUNKS  = 2,
    parameter int ROW_TILES = 3,
    parameter int COL_TILES = 3,
    parameter int K_W       = cnt_w(K_CHUNKS),
    parameter int R_W       = cnt_w(ROW_TILES),
    parameter int C_W       = cnt_w(COL_TILES)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           inc_k,
    input  logic           inc_tile,
    output logic [R_W-1:0] r_idx,
    output logic [C_W-1:0] c_idx,
    output logic [K_W-1:0] k_idx,
    output logic           last_k,
    output logic           last_tile
);
    logic last_c;
    logic last_r;

    assign last_k    = (k_idx == K_W'(K_CHUNKS - 1));
    assign last_c    = (c_idx == C_W'(COL_TILES - 1));
    assign last_r    = (r_idx == R_W'(ROW_TILES - 1));
    assign last_tile = last_c && last_r;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            k_idx <= '0;
            c_idx <= '0;
            r_idx <= '0;
        end else begin
            if (inc_k) k_idx <= last_k ? '0 : k_idx + 1'b1;
            if (inc_tile) begin
                if (last_c) begin
                    c_idx <= '0;
                    r_idx <= last_r ? '0 : r_idx + 1'b1;
                end else begin
                    c_idx <= c_idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/matmul_tile_sequencer.sv
// Tile scheduler for C = I x W: reads BRAM chunks, streams beats to the systolic core, writes results.
// Latency: 1 + K_CHUNKS + 3 cycles per tile minimum, plus one DONE cycle. MATMUL_SEQ_PERF_CNT_EN adds cycle_cnt.
// Backpressure: stalls in WAIT_CORE on core_ready and in WAIT_RES on core_out_valid; no mid-tile stall.
module matmul_tile_sequencer
    import matmul_seq_pkg::*;
#(
    parameter int WIDTH             = 16,
    parameter int CHUNK_SIZE        = 4,
    parameter int BLOCK_SIZE        = 2,
    parameter int INNER_DIMENSION   = 8,
    parameter int I_OUTER_DIMENSION = 6,
    parameter int W_OUTER_DIMENSION = 6,
    parameter int ADDR_W            = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    matmul_tile_sequencer_if.master bus
);
    localparam int DW        = WIDTH * CHUNK_SIZE;
    localparam int K_CHUNKS  = div_dim(INNER_DIMENSION, CHUNK_SIZE);
    localparam int ROW_TILES = div_dim(I_OUTER_DIMENSION, BLOCK_SIZE);
    localparam int COL_TILES = div_dim(W_OUTER_DIMENSION, BLOCK_SIZE);
    localparam int K_W       = cnt_w(K_CHUNKS);
    localparam int R_W       = cnt_w(ROW_TILES);
    localparam int C_W       = cnt_w(COL_TILES);
    localparam int MAX_SPAN  = max2(K_CHUNKS, COL_TILES);
    localparam logic [ADDR_W-1:0] K_A   = ADDR_W'(K_CHUNKS);
    localparam logic [ADDR_W-1:0] COL_A = ADDR_W'(COL_TILES);

    if (BLOCK_SIZE * BLOCK_SIZE != CHUNK_SIZE) begin : g_bad_block
        $error("BLOCK_SIZE*BLOCK_SIZE must equal CHUNK_SIZE");
    end
    if ((INNER_DIMENSION % CHUNK_SIZE) != 0 || (I_OUTER_DIMENSION % BLOCK_SIZE) != 0 ||
        (W_OUTER_DIMENSION % BLOCK_SIZE) != 0) begin : g_bad_div
        $error("matrix dimensions not divisible by chunk/block size");
    end
    if (longint'(ROW_TILES) * longint'(MAX_SPAN) > (longint'(1) << ADDR_W)) begin : g_bad_addr
        $error("ADDR_W too narrow for the tile address range");
    end

    seq_state_t     state, state_n;
    logic           cnt_clear, inc_k, inc_tile, last_k, last_tile;
    logic [R_W-1:0] r_idx;
    logic [C_W-1:0] c_idx;
    logic [K_W-1:0] k_idx;
    logic           acc_clr_q, in_vld_q, err_q;
    logic [DW-1:0]  res_q;
    logic           issuing, writing;

    tile_loop_counter #(
        .K_CHUNKS(K_CHUNKS), .ROW_TILES(ROW_TILES), .COL_TILES(COL_TILES),
        .K_W(K_W), .R_W(R_W), .C_W(C_W)
    ) u_loop (
        .clk(clk), .rst(rst), .clear(cnt_clear), .inc_k(inc_k), .inc_tile(inc_tile),
        .r_idx(r_idx), .c_idx(c_idx), .k_idx(k_idx), .last_k(last_k), .last_tile(last_tile)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        cnt_clear = 1'b0;
        inc_k     = 1'b0;
        inc_tile  = 1'b0;
        case (state)
            S_IDLE: if (bus.start) begin
                state_n   = S_WAIT_CORE;
                cnt_clear = 1'b1;
            end
            S_WAIT_CORE: if (bus.core_ready) state_n = S_ISSUE;
            S_ISSUE: begin
                inc_k = 1'b1;
                if (last_k) state_n = S_DRAIN;
            end
            S_DRAIN:    state_n = S_WAIT_RES;
            S_WAIT_RES: if (bus.core_out_valid) state_n = S_WRITE;
            S_WRITE: begin
                inc_tile = 1'b1;
                state_n  = last_tile ? S_DONE : S_WAIT_CORE;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // acc_clr is registered so it lands in the first ISSUE cycle, one cycle ahead of the first beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_clr_q <= 1'b0;
            in_vld_q  <= 1'b0;
            err_q     <= 1'b0;
            res_q     <= '0;
        end else begin
            acc_clr_q <= (state == S_WAIT_CORE) && bus.core_ready;
            in_vld_q  <= issuing;
            if (bus.core_out_valid && state != S_WAIT_RES) err_q <= 1'b1;
            if (bus.core_out_valid && state == S_WAIT_RES) res_q <= bus.core_out_data;
        end
    end

    assign issuing           = (state == S_ISSUE);
    assign writing           = (state == S_WRITE);
    assign bus.ready         = (state == S_IDLE);
    assign bus.done          = (state == S_DONE);
    assign bus.in_enb        = issuing;
    assign bus.wb_enb        = issuing;
    assign bus.in_addrb      = issuing ? ADDR_W'(r_idx) * K_A + ADDR_W'(k_idx) : '0;
    assign bus.wb_addrb      = issuing ? ADDR_W'(c_idx) * K_A + ADDR_W'(k_idx) : '0;
    assign bus.core_acc_clr  = acc_clr_q;
    assign bus.core_in_valid = in_vld_q;
    assign bus.core_in_data  = bus.in_doutb;
    assign bus.core_wb_data  = bus.wb_doutb;
    assign bus.out_wea       = writing;
    assign bus.out_addra     = writing ? ADDR_W'(r_idx) * COL_A + ADDR_W'(c_idx) : '0;
    assign bus.out_dina      = writing ? res_q : '0;
    assign bus.err           = err_q;

`ifdef MATMUL_SEQ_PERF_CNT_EN
    logic [31:0] perf_q;
    always_ff @(posedge clk) begin
        if (rst)                  perf_q <= '0;
        else if (state != S_IDLE) perf_q <= perf_q + 32'd1;
        else if (bus.start)       perf_q <= '0;
    end
    assign bus.cycle_cnt = perf_q;
`else
    assign bus.cycle_cnt = '0;
`endif
endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Randomised bench for matmul_tile_sequencer with BRAM and core models and a tile-walk reference.
module tb_matmul_tile_sequencer;
    localparam int WIDTH = 16, CHUNK = 4, BLOCK = 2, INNER = 8, IO = 6, WO = 6, ADDR_W = 14;
    localparam int DW = WIDTH * CHUNK;
    localparam int K = INNER / CHUNK;
    localparam int ROWS = IO / BLOCK;
    localparam int COLS = WO / BLOCK;
    localparam int TILES = ROWS * COLS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matmul_tile_sequencer_if #(.DW(DW), .ADDR_W(ADDR_W)) bus ();

    matmul_tile_sequencer #(
        .WIDTH(WIDTH), .CHUNK_SIZE(CHUNK), .BLOCK_SIZE(BLOCK), .INNER_DIMENSION(INNER),
        .I_OUTER_DIMENSION(IO), .W_OUTER_DIMENSION(WO), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    logic [DW-1:0]     in_mem [16];
    logic [DW-1:0]     wb_mem [16];
    logic [ADDR_W-1:0] in_log [$];
    logic [ADDR_W-1:0] wb_log [$];
    logic [ADDR_W-1:0] wr_addr [$];
    logic [DW-1:0]     wr_dat [$];
    int done_cnt, clr_cnt, checks, failures;
    logic [DW-1:0] acc, res;
    int beats, pend_cnt, res_delay;
    bit pend, spur_req;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of environment: sample DUT, run the core model, then answer BRAM reads.
    task automatic step();
        @(negedge clk);
        if (bus.in_enb) begin
            in_log.push_back(bus.in_addrb);
            wb_log.push_back(bus.wb_addrb);
        end
        if (bus.out_wea) begin
            wr_addr.push_back(bus.out_addra);
            wr_dat.push_back(bus.out_dina);
        end
        if (bus.done) done_cnt++;
        if (bus.core_acc_clr) clr_cnt++;
        bus.core_out_valid = 1'b0;
        if (pend) begin
            if (pend_cnt == 0) begin
                bus.core_out_valid = 1'b1;
                bus.core_out_data  = res;
                pend = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        if (bus.core_acc_clr) begin
            acc = '0;
            beats = 0;
        end else if (bus.core_in_valid) begin
            acc = acc + (bus.core_in_data ^ bus.core_wb_data);
            beats++;
            if (beats == K) begin
                res = acc;
                pend = 1'b1;
                pend_cnt = res_delay;
                beats = 0;
            end
        end
        if (spur_req && bus.in_enb) begin
            bus.core_out_valid = 1'b1;
            bus.core_out_data  = 64'hDEAD_BEEF_0BAD_F00D;
            spur_req = 1'b0;
        end
        if (bus.in_enb) bus.in_doutb = in_mem[bus.in_addrb[3:0]];
        if (bus.wb_enb) bus.wb_doutb = wb_mem[bus.wb_addrb[3:0]];
    endtask

    task automatic clear_logs();
        in_log.delete(); wb_log.delete(); wr_addr.delete(); wr_dat.delete();
        done_cnt = 0;
        clr_cnt  = 0;
    endtask

    // lowat >= 0: drop core_ready for 5 cycles right after that many tiles have been written.
    task automatic run_op(input int lowat);
        int budget, low_left, low_enb;
        bit dropped;
        low_left = 0; low_enb = 0; dropped = 0; budget = 0;
        for (int i = 0; i < 16; i++) begin
            in_mem[i] = {$urandom, $urandom};
            wb_mem[i] = {$urandom, $urandom};
        end
        clear_logs();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        while (done_cnt == 0 && budget < 2000) begin
            step();
            budget++;
            if (low_left > 0) begin
                if (bus.in_enb) low_enb++;
                low_left--;
                if (low_left == 0) bus.core_ready = 1'b1;
            end else if (!dropped && lowat >= 0 && bus.out_wea && wr_addr.size() == lowat) begin
                bus.core_ready = 1'b0;
                low_left = 5;
                dropped = 1'b1;
            end
        end
        chk("done_seen", done_cnt, 1);
        if (lowat >= 0) chk("enb_while_core_busy", low_enb, 0);
        step();
        chk("ready_after_done", bus.ready, 1);
        chk("single_done", done_cnt, 1);
        chk("acc_clr_per_tile", clr_cnt, TILES);
    endtask

    // Reference: row-major tiles, column inner, K chunks per tile; result is the core's XOR-sum.
    task automatic check_run(input int off);
        int n;
        logic [DW-1:0] e;
        n = 0;
        chk("issue_count", in_log.size() >= (off + 1) * TILES * K, 1);
        chk("write_count", wr_addr.size() >= (off + 1) * TILES, 1);
        if (in_log.size() >= (off + 1) * TILES * K && wr_addr.size() >= (off + 1) * TILES) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    e = '0;
                    for (int k = 0; k < K; k++) begin
                        chk("in_addrb", in_log[(off * TILES + n) * K + k], r * K + k);
                        chk("wb_addrb", wb_log[(off * TILES + n) * K + k], c * K + k);
                        e = e + (in_mem[r * K + k] ^ wb_mem[c * K + k]);
                    end
                    chk("out_addra", wr_addr[off * TILES + n], r * COLS + c);
                    chk("out_dina", wr_dat[off * TILES + n], e);
                    n++;
                end
            end
        end
    endtask

    initial begin
        int budget;
        checks = 0; failures = 0;
        acc = '0; res = '0; beats = 0; pend = 0; pend_cnt = 0; res_delay = 2; spur_req = 0;
        bus.start = 1'b0; bus.core_ready = 1'b1; bus.core_out_valid = 1'b0;
        bus.core_out_data = '0; bus.in_doutb = '0; bus.wb_doutb = '0;
        clear_logs();

        rst = 1'b1;
        repeat (3) step();
        chk("rst_ready", bus.ready, 1);
        chk("rst_done", bus.done, 0);
        chk("rst_in_enb", bus.in_enb, 0);
        chk("rst_wb_enb", bus.wb_enb, 0);
        chk("rst_acc_clr", bus.core_acc_clr, 0);
        chk("rst_in_valid", bus.core_in_valid, 0);
        chk("rst_out_wea", bus.out_wea, 0);
        chk("rst_out_addra", bus.out_addra, 0);
        chk("rst_in_addrb", bus.in_addrb, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_cycle_cnt", bus.cycle_cnt, 0);
        rst = 1'b0;
        step();

        // Plain run, core answers 2 cycles late.
        run_op(-1);
        check_run(0);
        if (in_log.size() >= 12) begin
            chk("t0_in0", in_log[0], 0);  chk("t0_in1", in_log[1], 1);
            chk("t0_wb0", wb_log[0], 0);  chk("t0_wb1", wb_log[1], 1);
            chk("t5_in0", in_log[10], 2); chk("t5_in1", in_log[11], 3);
            chk("t5_wb0", wb_log[10], 4); chk("t5_wb1", wb_log[11], 5);
        end
        chk("err_clean_run", bus.err, 0);

        // Spurious result while issuing.
        spur_req = 1'b1;
        run_op(-1);
        check_run(0);
        chk("err_after_spurious", bus.err, 1);

        // core_ready low for 5 cycles after tile 3; err must stay sticky.
        run_op(3);
        check_run(0);
        chk("err_sticky", bus.err, 1);

        // start held high across two operations.
        clear_logs();
        bus.start = 1'b1;
        budget = 0;
        while (done_cnt < 1 && budget < 2000) begin step(); budget++; end
        chk("held_first_done", done_cnt, 1);
        chk("held_writes_first", wr_addr.size(), TILES);
        step();
        chk("held_back_in_idle", bus.ready, 1);
        budget = 0;
        while (done_cnt < 2 && budget < 2000) begin step(); budget++; end
        bus.start = 1'b0;
        chk("held_second_done", done_cnt, 2);
        check_run(1);
        repeat (5) step();
        chk("held_no_third", done_cnt, 2);
        chk("held_issue_total", in_log.size(), 2 * TILES * K);

        // Reset while tile 4 waits for its result.
        res_delay = 3;
        clear_logs();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        budget = 0;
        while (!(wr_addr.size() == 4 && pend) && budget < 2000) begin step(); budget++; end
        chk("reached_tile4_drain", budget < 2000, 1);
        step();
        rst = 1'b1;
        pend = 1'b0;
        step();
        chk("mid_rst_ready", bus.ready, 1);
        chk("mid_rst_in_enb", bus.in_enb, 0);
        chk("mid_rst_wb_enb", bus.wb_enb, 0);
        chk("mid_rst_out_wea", bus.out_wea, 0);
        chk("mid_rst_in_valid", bus.core_in_valid, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_err", bus.err, 0);
        rst = 1'b0;
        repeat (10) step();
        chk("mid_rst_no_done", done_cnt, 0);
        chk("mid_rst_idle", bus.ready, 1);
        res_delay = 2;
        run_op(-1);
        check_run(0);
        chk("restart_err", bus.err, 0);

        // Zero-delay core for the performance counter.
        res_delay = 0;
        run_op(-1);
        check_run(0);
`ifdef MATMUL_SEQ_PERF_CNT_EN
        chk("cycle_cnt_at_done", bus.cycle_cnt, 55);
        repeat (3) step();
        chk("cycle_cnt_hold", bus.cycle_cnt, 55);
`else
        chk("cycle_cnt_tied", bus.cycle_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
